// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage.
// Holds the next-PC select encodings, address-map defaults and the nop encoding.
package fetch_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned IDX_W  = 26;
  localparam int unsigned NSEL_W = 2;

  // Next-PC select encodings, shared with the D-stage controller
  typedef enum logic [NSEL_W-1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [XLEN-1:0] DEF_PC_RESET = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_IM_LIMIT = 32'h0000_6FFC;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Combinational next-PC selection: sequential, branch, jump and jump-register targets.
// Branch and jump targets are relative to the instruction in D (pc_d), not to the PC.
module fetch_stage_npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_pc_d,
  input  logic [NSEL_W-1:0] i_npc_sel,
  input  logic              i_cmp_true,
  input  logic [IMM_W-1:0]  i_imm16,
  input  logic [IDX_W-1:0]  i_index26,
  input  logic [XLEN-1:0]   i_rs_val,
  output logic [XLEN-1:0]   o_npc
);

  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_br_off;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_j_tgt;

  assign w_pc4    = i_pc + 32'd4;
  assign w_br_off = {{(XLEN-IMM_W-2){i_imm16[IMM_W-1]}}, i_imm16, 2'b00};
  assign w_br_tgt = i_pc_d + 32'd4 + w_br_off;
  assign w_j_tgt  = {i_pc_d[XLEN-1:XLEN-4], i_index26, 2'b00};

  always_comb begin
    o_npc = w_pc4;
    case (npc_sel_e'(i_npc_sel))
      NPC_SEQ: o_npc = w_pc4;
      NPC_BR:  o_npc = i_cmp_true ? w_br_tgt : w_pc4;
      NPC_J:   o_npc = w_j_tgt;
      NPC_JR:  o_npc = i_rs_val;
      default: o_npc = w_pc4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch-address check and the F/D pipeline register.
// The instruction in F when D redirects is always latched (single branch delay slot).
module fetch_stage #(
  parameter logic [31:0] PC_RESET = fetch_stage_pkg::DEF_PC_RESET,
  parameter logic [31:0] IM_BASE  = fetch_stage_pkg::DEF_IM_BASE,
  parameter logic [31:0] IM_LIMIT = fetch_stage_pkg::DEF_IM_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        cmp_true,
  input  logic [15:0] imm16_D,
  input  logic [25:0] index26_D,
  input  logic [31:0] rs_val_D,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        fetch_exc_D
);

  import fetch_stage_pkg::*;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_d;
  logic            r_exc;
  logic [XLEN-1:0] w_npc;
  logic            w_bad;

  fetch_stage_npc_calc u_npc_calc (
    .i_pc       (r_pc),
    .i_pc_d     (r_pc_d),
    .i_npc_sel  (npc_sel),
    .i_cmp_true (cmp_true),
    .i_imm16    (imm16_D),
    .i_index26  (index26_D),
    .i_rs_val   (rs_val_D),
    .o_npc      (w_npc)
  );

  // Misaligned or out-of-window fetches are turned into a nop plus an exception flag
  assign w_bad = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= PC_RESET;
      r_instr <= NOP_INSTR;
      r_pc_d  <= '0;
      r_exc   <= 1'b0;
    end else if (!stall) begin
      r_pc    <= w_npc;
      r_instr <= w_bad ? NOP_INSTR : i_inst_rdata;
      r_pc_d  <= r_pc;
      r_exc   <= w_bad;
    end
  end

  assign i_inst_addr = r_pc;
  assign instr_D     = r_instr;
  assign pc_D        = r_pc_d;
  assign pc8_D       = r_pc_d + 32'd8;
  assign fetch_exc_D = r_exc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random traffic
// compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        cmp_true;
  logic [15:0] imm16_D;
  logic [25:0] index26_D;
  logic [31:0] rs_val_D;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic        fetch_exc_D;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pcd;
  logic        m_exc;

  logic [31:0] hold_addr, hold_pcd, hold_instr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .npc_sel      (npc_sel),
    .cmp_true     (cmp_true),
    .imm16_D      (imm16_D),
    .index26_D    (index26_D),
    .rs_val_D     (rs_val_D),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .instr_D      (instr_D),
    .pc_D         (pc_D),
    .pc8_D        (pc8_D),
    .fetch_exc_D  (fetch_exc_D)
  );

  // instruction memory: a distinct, address-derived word for every location
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  // Compare all outputs with the model, then apply one clock edge to both.
  task automatic step(input logic rst, input logic st, input logic [1:0] sel,
                      input logic cmp, input logic [15:0] imm,
                      input logic [25:0] idx, input logic [31:0] rs);
    logic [31:0] nxt;
    int off;
    @(negedge clk);
    reset = rst; stall = st; npc_sel = sel; cmp_true = cmp;
    imm16_D = imm; index26_D = idx; rs_val_D = rs;
    #1;
    check("inst_addr", i_inst_addr, m_pc);
    check("instr_D", instr_D, m_instr);
    check("pc_D", pc_D, m_pcd);
    check("pc8_D", pc8_D, m_pcd + 32'd8);
    check("fetch_exc_D", 32'(fetch_exc_D), 32'(m_exc));
    if (rst) begin
      m_pc = 32'h3000; m_instr = 0; m_pcd = 0; m_exc = 0;
    end else if (!st) begin
      off = int'($signed(imm));
      case (sel)
        2'd0: nxt = m_pc + 4;
        2'd1: nxt = cmp ? m_pcd + 4 + 32'(off * 4) : m_pc + 4;
        2'd2: nxt = (m_pcd & 32'hF000_0000) | (32'(idx) * 4);
        default: nxt = rs;
      endcase
      m_exc   = is_bad(m_pc);
      m_instr = m_exc ? 32'h0 : mem_word(m_pc);
      m_pcd   = m_pc;
      m_pc    = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic seq();
    step(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  initial begin
    reset = 1; stall = 0; npc_sel = 0; cmp_true = 0;
    imm16_D = 0; index26_D = 0; rs_val_D = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_pc = 32'h3000; m_instr = 0; m_pcd = 0; m_exc = 0;
    reset = 0;
    check("reset_addr", i_inst_addr, 32'h3000);
    check("reset_instr", instr_D, 32'h0);
    check("reset_exc", 32'(fetch_exc_D), 32'h0);

    // sequential fetch
    seq();
    check("seq1_addr", i_inst_addr, 32'h3004);
    check("seq1_pcd", pc_D, 32'h3000);
    check("seq1_pc8", pc8_D, 32'h3008);
    seq(); seq(); seq();
    check("seq4_addr", i_inst_addr, 32'h3010);
    check("seq4_pcd", pc_D, 32'h300C);
    seq();
    check("pre_br_pcd", pc_D, 32'h3010);

    // taken backward branch; delay slot 0x3014 latched
    step(0, 0, 2'd1, 1, 16'hFFFC, 26'h0, 32'h0);
    check("br_taken_addr", i_inst_addr, 32'h3004);
    check("br_slot_pcd", pc_D, 32'h3014);
    check("br_slot_instr", instr_D, mem_word(32'h3014));

    // not-taken branch
    step(0, 0, 2'd1, 0, 16'hFFFC, 26'h0, 32'h0);
    check("br_nt_addr", i_inst_addr, 32'h3008);

    // jump from pc_D = 0x3020
    step(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3020);
    seq();
    check("pre_j_pcd", pc_D, 32'h3020);
    step(0, 0, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0);
    check("j_addr", i_inst_addr, 32'h3100);

    // misaligned jr target
    step(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3002);
    seq();
    check("jr_mis_instr", instr_D, 32'h0);
    check("jr_mis_exc", 32'(fetch_exc_D), 32'h1);
    check("jr_mis_pcd", pc_D, 32'h3002);

    // stall held 3 cycles with a pending jump
    step(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3040);
    seq();
    hold_addr = i_inst_addr; hold_pcd = pc_D; hold_instr = instr_D;
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 2'd2, 0, 16'h0, 26'h0000D00, 32'h0);
      check("stall_addr", i_inst_addr, hold_addr);
      check("stall_pcd", pc_D, hold_pcd);
      check("stall_instr", instr_D, hold_instr);
    end
    step(0, 0, 2'd2, 0, 16'h0, 26'h0000D00, 32'h0);
    check("unstall_j_addr", i_inst_addr, 32'h3400);

    // reset during stall
    step(1, 1, 2'd2, 0, 16'h0, 26'h0000D00, 32'h0);
    check("rst_stall_addr", i_inst_addr, 32'h3000);
    check("rst_stall_instr", instr_D, 32'h0);
    check("rst_stall_exc", 32'(fetch_exc_D), 32'h0);

    // PC wraps past the top of the address space
    step(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    seq();
    check("wrap_addr", i_inst_addr, 32'h0);
    check("wrap_exc_hi", 32'(fetch_exc_D), 32'h1);
    seq();
    check("wrap_exc_lo", 32'(fetch_exc_D), 32'h1);

    // random traffic, mostly inside the legal window
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rs;
      rs = ($urandom_range(0, 7) == 0) ? $urandom()
           : 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 4;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           16'($signed($urandom_range(0, 200)) - 100),
           ($urandom_range(0, 3) == 0) ? 26'($urandom()) : 26'(32'hC00 + $urandom_range(0, 32'hFFF)),
           rs);
    end
    seq();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (F) stage of the pipelined MIPS core, directly upstream of the decode-stage field splitter.
- Holds the PC and drives the external instruction-memory address.
- Computes the next PC from sequential, branch, jump and jump-register requests resolved in D.
- Registers the fetched instruction and its PC into the F/D pipeline register that feeds decode.
- One architectural branch delay slot: the instruction already in F when D redirects always proceeds.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard-unit stall: hold PC and F/D register
npc_sel  in  2  next-PC select from D-stage control: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr
cmp_true  in  1  D-stage branch condition result, used only when npc_sel==1
imm16_D  in  16  immediate field of the instruction in D
index26_D  in  26  jump index field of the instruction in D
rs_val_D  in  32  forwarded rs value in D (jr target)
i_inst_addr  out  32  instruction-memory address (= PC, combinational)
i_inst_rdata  in  32  instruction word returned same cycle for i_inst_addr
instr_D  out  32  registered instruction for decode
pc_D  out  32  registered PC of instr_D
pc8_D  out  32  pc_D + 8, link address for jal/jalr
fetch_exc_D  out  1  registered fetch-address exception flag for instr_D

Behaviour:
- Reset (clk edge with reset=1): PC<=PC_RESET; instr_D<=0; pc_D<=0; fetch_exc_D<=0. reset overrides stall and npc_sel.
- i_inst_addr = PC at all times. Memory is combinational-read: no wait states, zero fetch latency.
- Fetch-address check (combinational on PC): bad = PC[1:0]!=0 OR PC<IM_BASE OR PC>IM_LIMIT.
- F/D update, when stall=0:
  - instr_D <= bad ? 32'h0 : i_inst_rdata
  - pc_D <= PC
  - fetch_exc_D <= bad
- pc8_D = pc_D + 8, combinational from the register.
- Next PC, when stall=0:
  - 0: PC+4
  - 1: cmp_true ? pc_D+4+(sext(imm16_D)<<2) : PC+4
  - 2: {pc_D[31:28], index26_D, 2'b00}
  - 3: rs_val_D, taken unmodified; a misaligned value is flagged on its fetch, not corrected
- All adds are modulo 2^32; PC wraps from 0xFFFF_FFFC to 0x0 silently. The bad flag still catches the wrapped address.
- Delay slot: on redirect, the instruction currently in F (pc_D+4) is latched into F/D normally. It is never squashed.
- stall=1: PC, instr_D, pc_D, fetch_exc_D all hold. npc_sel is ignored that cycle; D re-presents the same control next cycle.
- Simultaneous stall and redirect: stall wins, and the redirect takes effect on the first unstalled cycle.
- Reset asserted mid-stall or mid-redirect: reset wins. The pipeline restarts at PC_RESET with a nop in D.
- npc_sel encodings are exhaustive; no illegal value exists.

Decomposition:
- Shared CPU package holds:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR 2-bit encodings, shared with the controller
  - PC_RESET, IM_BASE and IM_LIMIT defaults
  - NOP_INSTR = 32'h0
- One combinational sub-module, npc_calc:
  - inputs: PC, pc_D, npc_sel, cmp_true, imm16_D, index26_D, rs_val_D
  - output: npc
- PC register and F/D register stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles with stall=0, npc_sel=0 -> i_inst_addr 0x3000, 0x3004, 0x3008, 0x300C; pc_D lags by one cycle; pc8_D = pc_D+8.
- Branch taken, backward offset:
  - setup: pc_D=0x3010, npc_sel=1, cmp_true=1, imm16_D=0xFFFC
  - required: next PC = 0x3004
  - required: the delay-slot instruction at 0x3014 appears in instr_D first
- Branch not taken: same setup with cmp_true=0 -> next PC = current PC+4.
- Jump:
  - setup: pc_D=0x3020, npc_sel=2, index26_D=0x0000C40
  - required: next PC = 0x0000_3100
- Jump register, misaligned target:
  - setup: npc_sel=3, rs_val_D=0x0000_3002
  - required: the following cycle instr_D=0 and fetch_exc_D=1 with pc_D=0x3002
- Stall held 3 cycles while npc_sel=2 -> PC and F/D unchanged for all 3 cycles; the jump is applied on the cycle stall drops.
- Reset asserted during stall -> next edge gives PC=0x3000, instr_D=0, fetch_exc_D=0.
